// File: rtl/axi_rd_burst_master.sv
// AXI3 read master: turns one read request into 4 KB-safe aligned INCR bursts, keeps up to
// MAX_OUTSTANDING bursts in flight and streams returned beats straight into the input buffer.
module axi_rd_burst_master #(
    parameter int C_M_AXI_DATA_WIDTH      = 64,
    parameter int C_M_AXI_RD_BURST_LEN    = 16,
    parameter int C_M_AXI_THREAD_ID_WIDTH = 6,
    parameter int TX_SIZE_WIDTH           = 10,
    parameter int MAX_OUTSTANDING         = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               rx_req,
    input  logic [31:0]                        rx_addr,
    input  logic [TX_SIZE_WIDTH-1:0]           rx_req_size,
    output logic                               rx_ready,
    output logic                               rx_done,
    output logic                               rd_idle,
    output logic                               rd_error,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [31:0]                        M_AXI_ARADDR,
    output logic [3:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      data_to_inBuf,
    output logic                               inBuf_push,
    input  logic                               inBuf_full
);

    localparam int BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
    localparam int ALIGN_BITS     = $clog2(C_M_AXI_RD_BURST_LEN * BYTES_PER_BEAT);
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1);
    localparam int LEN_W          = 5;

    // Aligning the start to a full-burst boundary is what keeps every burst inside one 4 KB page.
    localparam logic [31:0]              ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);
    localparam logic [TX_SIZE_WIDTH-1:0] MAX_BURST  = TX_SIZE_WIDTH'(C_M_AXI_RD_BURST_LEN);
    localparam logic [OUT_W-1:0]         OUT_LIMIT  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    state_t                   state, state_next;
    logic [31:0]              ar_addr;
    logic [3:0]               ar_len;
    logic [TX_SIZE_WIDTH-1:0] remaining, remaining_after;
    logic [LEN_W-1:0]         burst_len;
    logic [OUT_W-1:0]         outstanding, outstanding_next;
    logic                     rready, ar_hs, r_hs, rlast_hs, req_start;

    function automatic logic [3:0] arlen_for(input logic [TX_SIZE_WIDTH-1:0] beats);
        if (beats == '0) return 4'd0;
        if (beats >= MAX_BURST) return 4'(C_M_AXI_RD_BURST_LEN - 1);
        return 4'(beats - 1'b1);
    endfunction

    assign rready          = !inBuf_full;
    assign ar_hs           = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs            = M_AXI_RVALID && rready;
    assign rlast_hs        = r_hs && M_AXI_RLAST;
    assign req_start       = (state == IDLE) && rx_req && (rx_req_size != '0);
    assign burst_len       = (remaining >= MAX_BURST) ? LEN_W'(C_M_AXI_RD_BURST_LEN)
                                                      : LEN_W'(remaining);
    assign remaining_after = remaining - TX_SIZE_WIDTH'(burst_len);

    // An AR accept and a burst completion in the same cycle cancel out.
    always_comb begin
        outstanding_next = outstanding;
        if (ar_hs && !rlast_hs)
            outstanding_next = outstanding + 1'b1;
        else if (rlast_hs && !ar_hs)
            outstanding_next = outstanding - 1'b1;
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (rx_req) state_next = (rx_req_size != '0) ? ADDR : DONE;
            ADDR: begin
                if (ar_hs) begin
                    if (remaining_after == '0)
                        state_next = DONE;
                    else if (outstanding_next >= OUT_LIMIT)
                        state_next = WAIT;
                end
            end
            WAIT: if (outstanding_next < OUT_LIMIT) state_next = ADDR;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            ar_addr     <= '0;
            ar_len      <= '0;
            remaining   <= '0;
            outstanding <= '0;
            rd_error    <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (req_start) begin
                ar_addr   <= rx_addr & ALIGN_MASK;
                remaining <= rx_req_size;
                ar_len    <= arlen_for(rx_req_size);
            end else if (ar_hs) begin
                ar_addr   <= ar_addr + (32'(burst_len) << SIZE_LOG2);
                remaining <= remaining_after;
                ar_len    <= arlen_for(remaining_after);
            end
            // A new request wins over a late error beat from the previous one.
            if (req_start)
                rd_error <= 1'b0;
            else if (r_hs && (M_AXI_RRESP != 2'b00))
                rd_error <= 1'b1;
        end
    end

    assign rx_ready      = (state == IDLE);
    assign rx_done       = (state == DONE);
    assign rd_idle       = (state == IDLE) && (outstanding == '0);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARLEN   = ar_len;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = (state == ADDR);

    assign M_AXI_RREADY  = rready;
    assign inBuf_push    = r_hs;
    assign data_to_inBuf = M_AXI_RDATA;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Testbench for axi_rd_burst_master: an AXI read-slave model with AR/R scoreboards, a table of
// requests under varied back-pressure, and directed sequences for latency, WAIT, stall, error, reset.
module tb_axi_rd_burst_master;

    localparam int DW   = 64;
    localparam int BL   = 16;
    localparam int IDW  = 6;
    localparam int TSW  = 10;
    localparam int MAXO = 4;

    logic            ACLK;
    logic            ARESETN;
    logic            rx_req;
    logic [31:0]     rx_addr;
    logic [TSW-1:0]  rx_req_size;
    logic            rx_ready, rx_done, rd_idle, rd_error;
    logic [IDW-1:0]  arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid, arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast, rvalid, rready;
    logic [DW-1:0]   data_to_inbuf;
    logic            inbuf_push, inbuf_full;

    axi_rd_burst_master #(
        .C_M_AXI_DATA_WIDTH     (DW),
        .C_M_AXI_RD_BURST_LEN   (BL),
        .C_M_AXI_THREAD_ID_WIDTH(IDW),
        .TX_SIZE_WIDTH          (TSW),
        .MAX_OUTSTANDING        (MAXO)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .rx_req       (rx_req),
        .rx_addr      (rx_addr),
        .rx_req_size  (rx_req_size),
        .rx_ready     (rx_ready),
        .rx_done      (rx_done),
        .rd_idle      (rd_idle),
        .rd_error     (rd_error),
        .M_AXI_ARID   (arid),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARLEN  (arlen),
        .M_AXI_ARSIZE (arsize),
        .M_AXI_ARBURST(arburst),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RLAST  (rlast),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready),
        .data_to_inBuf(data_to_inbuf),
        .inBuf_push   (inbuf_push),
        .inBuf_full   (inbuf_full)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    typedef struct {
        logic [31:0] addr;
        int          size;
        bit          rand_ready;
        bit          rand_full;
        int          exp_ars;
        logic [31:0] exp_last_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    ar_t           exp_ar_q[$];
    int            burst_q[$];
    logic [DW-1:0] exp_data_q[$];

    int          ar_count = 0, push_count = 0, done_count = 0;
    int          ar_base = 0, push_base = 0, done_base = 0;
    int          req_beat = 0, err_beat = -1, beat_in_burst = 0;
    int unsigned beat_id = 0;
    logic [31:0] last_araddr = '0;
    bit          slave_en = 1'b1, auto_ctl = 1'b0, rand_ready = 1'b0, rand_full = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [3:0]  prev_len = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual %0h required nothing", name, act);
    endtask

    // Reference burst split: 128-byte aligned start, up to 16 beats of 8 bytes each.
    task automatic model_bursts(input logic [31:0] addr, input int size);
        logic [31:0] a;
        int rem, len;
        ar_t e;
        a   = addr & 32'hFFFF_FF80;
        rem = size;
        while (rem > 0) begin
            len    = (rem > BL) ? BL : rem;
            e.addr = a;
            e.len  = 4'(len - 1);
            exp_ar_q.push_back(e);
            a   = a + 32'(len * 8);
            rem = rem - len;
        end
    endtask

    // Monitor on the falling edge, slave response driven just after the rising edge.
    initial begin
        bit  r_hs;
        ar_t e;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
        forever begin
            @(negedge ACLK);
            r_hs = 1'b0;
            if (ARESETN) begin
                if (prev_pending) begin
                    check("ar_hold_valid", 64'(arvalid), 1);
                    check("ar_hold_addr", 64'(araddr), 64'(prev_addr));
                    check("ar_hold_len", 64'(arlen), 64'(prev_len));
                end
                prev_pending = arvalid && !arready;
                prev_addr    = araddr;
                prev_len     = arlen;
                if (arvalid && arready) begin
                    ar_count++;
                    last_araddr = araddr;
                    if (exp_ar_q.size() == 0) fail_event("ar_unexpected", 64'(araddr));
                    else begin
                        e = exp_ar_q.pop_front();
                        check("ar_addr", 64'(araddr), 64'(e.addr));
                        check("ar_len", 64'(arlen), 64'(e.len));
                    end
                    burst_q.push_back(int'(arlen) + 1);
                end
                if (inbuf_push) begin
                    push_count++;
                    if (exp_data_q.size() == 0) fail_event("push_unexpected", 64'(data_to_inbuf));
                    else check("push_data", 64'(data_to_inbuf), 64'(exp_data_q.pop_front()));
                end
                if (rx_done) done_count++;
                r_hs = rvalid && rready;
            end
            @(posedge ACLK);
            #1;
            if (r_hs) begin
                req_beat++;
                rvalid = 1'b0;
                if (rlast) begin
                    if (burst_q.size() > 0) burst_q.delete(0);
                    beat_in_burst = 0;
                end else begin
                    beat_in_burst++;
                end
            end
            if (!rvalid && slave_en && burst_q.size() > 0) begin
                beat_id++;
                rdata  = {beat_id, ~beat_id};
                rlast  = (beat_in_burst == burst_q[0] - 1);
                rresp  = (req_beat == err_beat) ? 2'b10 : 2'b00;
                rvalid = 1'b1;
                exp_data_q.push_back({beat_id, ~beat_id});
            end
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (auto_ctl) begin
                arready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                inbuf_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic send_req(input logic [31:0] addr, input int size);
        model_bursts(addr, size);
        ar_base     = ar_count;
        push_base   = push_count;
        done_base   = done_count;
        req_beat    = 0;
        rx_addr     = addr;
        rx_req_size = TSW'(size);
        rx_req      = 1'b1;
        @(posedge ACLK);
        #1;
        rx_req      = 1'b0;
        rx_addr     = $urandom;
        rx_req_size = TSW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge ACLK);
            if (rd_idle) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) fail_event({name, "_timeout"}, 64'(rd_idle));
    endtask

    task automatic check_req(input string name, input int exp_ars, input int exp_beats,
                             input logic [31:0] exp_last);
        check({name, "_ar_count"}, 64'(ar_count - ar_base), 64'(exp_ars));
        check({name, "_push_count"}, 64'(push_count - push_base), 64'(exp_beats));
        check({name, "_done_pulses"}, 64'(done_count - done_base), 1);
        check({name, "_ar_left"}, 64'(exp_ar_q.size()), 0);
        check({name, "_data_left"}, 64'(exp_data_q.size()), 0);
        if (exp_ars > 0) check({name, "_last_araddr"}, 64'(last_araddr), 64'(exp_last));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_arvalid"}, 64'(arvalid), 0);
        check({name, "_araddr"}, 64'(araddr), 0);
        check({name, "_arlen"}, 64'(arlen), 0);
        check({name, "_rx_done"}, 64'(rx_done), 0);
        check({name, "_rd_error"}, 64'(rd_error), 0);
        check({name, "_rx_ready"}, 64'(rx_ready), 1);
        check({name, "_rd_idle"}, 64'(rd_idle), 1);
        check({name, "_arid"}, 64'(arid), 0);
        check({name, "_arsize"}, 64'(arsize), 3);
        check({name, "_arburst"}, 64'(arburst), 1);
    endtask

    initial begin
        vec_t vecs[7];
        bit   found, early;

        vecs[0] = '{addr: 32'h0000_1000, size: 16,  rand_ready: 0, rand_full: 0, exp_ars: 1, exp_last_addr: 32'h0000_1000};
        vecs[1] = '{addr: 32'h0000_2000, size: 40,  rand_ready: 0, rand_full: 0, exp_ars: 3, exp_last_addr: 32'h0000_2100};
        vecs[2] = '{addr: 32'h0000_3004, size: 17,  rand_ready: 1, rand_full: 0, exp_ars: 2, exp_last_addr: 32'h0000_3080};
        vecs[3] = '{addr: 32'hFFFF_FF80, size: 32,  rand_ready: 0, rand_full: 1, exp_ars: 2, exp_last_addr: 32'h0000_0000};
        vecs[4] = '{addr: 32'h0000_4000, size: 100, rand_ready: 1, rand_full: 1, exp_ars: 7, exp_last_addr: 32'h0000_4300};
        vecs[5] = '{addr: 32'h0000_5000, size: 0,   rand_ready: 0, rand_full: 0, exp_ars: 0, exp_last_addr: 32'h0000_0000};
        vecs[6] = '{addr: 32'h0000_6050, size: 1,   rand_ready: 1, rand_full: 1, exp_ars: 1, exp_last_addr: 32'h0000_6000};

        ARESETN     = 1'b0;
        rx_req      = 1'b0;
        rx_addr     = '0;
        rx_req_size = '0;
        arready     = 1'b0;
        inbuf_full  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("reset");
        #1;

        // Single burst: ARVALID the cycle after acceptance, rx_done the cycle after the AR handshake.
        arready = 1'b1;
        send_req(32'h0000_1000, 16);
        @(negedge ACLK);
        check("lat_arvalid", 64'(arvalid), 1);
        check("lat_araddr", 64'(araddr), 64'h1000);
        check("lat_arlen", 64'(arlen), 15);
        check("lat_rx_ready", 64'(rx_ready), 0);
        check("lat_rx_done_early", 64'(rx_done), 0);
        @(negedge ACLK);
        check("lat_rx_done", 64'(rx_done), 1);
        check("lat_arvalid_off", 64'(arvalid), 0);
        @(negedge ACLK);
        check("lat_rx_done_pulse", 64'(rx_done), 0);
        wait_idle("lat");
        check_req("lat", 1, 16, 32'h0000_1000);
        check("lat_rd_idle", 64'(rd_idle), 1);

        foreach (vecs[i]) begin
            rand_ready = vecs[i].rand_ready;
            rand_full  = vecs[i].rand_full;
            auto_ctl   = 1'b1;
            send_req(vecs[i].addr, vecs[i].size);
            wait_idle($sformatf("vec%0d", i));
            check_req($sformatf("vec%0d", i), vecs[i].exp_ars, vecs[i].size, vecs[i].exp_last_addr);
            auto_ctl   = 1'b0;
            arready    = 1'b1;
            inbuf_full = 1'b0;
        end

        // Outstanding limit: four bursts then WAIT until the first RLAST handshake.
        slave_en = 1'b0;
        arready  = 1'b1;
        send_req(32'h0000_7000, 100);
        repeat (8) @(negedge ACLK);
        #1;
        check("wait_ar_count", 64'(ar_count - ar_base), 4);
        check("wait_arvalid", 64'(arvalid), 0);
        slave_en = 1'b1;
        found = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK);
            if (arvalid) early = 1'b1;
            if (rvalid && rready && rlast) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_no_early_ar", 64'(early), 0);
        check("wait_rlast_seen", 64'(found), 1);
        @(negedge ACLK);
        check("wait_exit_arvalid", 64'(arvalid), 1);
        check("wait_exit_araddr", 64'(araddr), 64'h7200);
        wait_idle("wait");
        check_req("wait", 7, 100, 32'h0000_7300);

        // Input buffer full for three cycles with a beat held valid.
        send_req(32'h0000_8000, 16);
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            #1;
            if (push_count - push_base >= 5) break;
        end
        @(posedge ACLK);
        #1;
        inbuf_full = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            check("stall_rready", 64'(rready), 0);
            check("stall_push", 64'(inbuf_push), 0);
            check("stall_rvalid", 64'(rvalid), 1);
            @(posedge ACLK);
            #1;
        end
        inbuf_full = 1'b0;
        wait_idle("stall");
        check_req("stall", 1, 16, 32'h0000_8000);

        // Error response on the fifth beat is sticky until the next request.
        err_beat = 4;
        send_req(32'h0000_9000, 16);
        wait_idle("err");
        check_req("err", 1, 16, 32'h0000_9000);
        check("err_sticky", 64'(rd_error), 1);
        err_beat = -1;
        send_req(32'h0000_A000, 1);
        @(negedge ACLK);
        check("err_cleared", 64'(rd_error), 0);
        wait_idle("err_next");
        check_req("err_next", 1, 1, 32'h0000_A000);
        check("err_still_clear", 64'(rd_error), 0);

        // Asynchronous reset with ARVALID high and two bursts outstanding.
        slave_en = 1'b0;
        arready  = 1'b0;
        send_req(32'h0000_B000, 100);
        arready = 1'b1;
        @(posedge ACLK);
        #1;
        @(posedge ACLK);
        #1;
        arready = 1'b0;
        @(negedge ACLK);
        check("rst_pre_arvalid", 64'(arvalid), 1);
        check("rst_pre_araddr", 64'(araddr), 64'hB100);
        check("rst_pre_rd_idle", 64'(rd_idle), 0);
        #2;
        ARESETN = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_ar_q.delete();
        burst_q.delete();
        exp_data_q.delete();
        beat_in_burst = 0;
        rvalid        = 1'b0;
        prev_pending  = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN  = 1'b1;
        slave_en = 1'b1;
        arready  = 1'b1;
        send_req(32'h0000_C000, 1);
        @(negedge ACLK);
        check("post_rst_arlen", 64'(arlen), 0);
        check("post_rst_araddr", 64'(araddr), 64'hC000);
        wait_idle("post_rst");
        check_req("post_rst", 1, 1, 32'h0000_C000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
